// File: rtl/tv80_pkg.sv
// Shared types and constants for the tv80 opcode-prefix sequencer.
//   grp_t       : instruction group reported with each decoded record
//   idx_t       : index-register selection (HL / IX / IY)
//   pfx_state_t : prefix-chain FSM states
//   PFX_*       : the four prefix byte values
package tv80_pkg;

  typedef enum logic [1:0] {
    GRP_BASE = 2'b00,
    GRP_CB   = 2'b01,
    GRP_ED   = 2'b10,
    GRP_XYCB = 2'b11
  } grp_t;

  typedef enum logic [1:0] {
    IDX_HL = 2'b00,
    IDX_IX = 2'b01,
    IDX_IY = 2'b10
  } idx_t;

  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_CB = 8'hCB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_XY,
    S_P_CB,
    S_P_ED,
    S_XYCB_D,
    S_XYCB_OP
  } pfx_state_t;

endpackage

// File: rtl/tv80_prefix_seq_if.sv
// Byte-in / record-out bus of the tv80 prefix sequencer.
//   byte_valid/byte_ready/byte_in : fetched opcode/displacement byte stream
//   instr_valid/instr_ready       : decoded-record handshake
//   opcode, grp, idx, disp, nprefix : decoded record fields
//   in_prefix, int_ok             : sequence status
// master = the sequencer, slave = the fetch/executor side.
interface tv80_prefix_seq_if #(
  parameter int unsigned PFX_CNT_W = 4
);
  logic                 byte_valid;
  logic                 byte_ready;
  logic [7:0]           byte_in;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [7:0]           opcode;
  logic [1:0]           grp;
  logic [1:0]           idx;
  logic [7:0]           disp;
  logic [PFX_CNT_W-1:0] nprefix;
  logic                 in_prefix;
  logic                 int_ok;

  modport master (
    input  byte_valid, byte_in, instr_ready,
    output byte_ready, instr_valid, opcode, grp, idx, disp, nprefix,
           in_prefix, int_ok
  );

  modport slave (
    output byte_valid, byte_in, instr_ready,
    input  byte_ready, instr_valid, opcode, grp, idx, disp, nprefix,
           in_prefix, int_ok
  );
endinterface

// File: rtl/tv80_prefix_seq.sv
// tv80 opcode-prefix sequencer.
// Consumes fetched bytes, follows DD/FD/CB/ED prefix chains (including
// DD/FD CB d op) and emits one registered record per instruction.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tv80_prefix_seq_if.master (byte stream in, record out,
//                in_prefix / int_ok status)
module tv80_prefix_seq
  import tv80_pkg::*;
#(
  parameter int unsigned PFX_CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  tv80_prefix_seq_if.master  bus
);

  pfx_state_t           state_q, state_d;
  idx_t                 idx_q, idx_d;
  logic [PFX_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]           disp_q, disp_d;

  logic                 rec_vld_q;
  logic [7:0]           rec_op_q;
  grp_t                 rec_grp_q;
  idx_t                 rec_idx_q;
  logic [7:0]           rec_disp_q;
  logic [PFX_CNT_W-1:0] rec_np_q;

  logic                 accept;
  logic                 emit;
  grp_t                 e_grp;
  idx_t                 e_idx;
  logic [PFX_CNT_W-1:0] cnt_base;
  idx_t                 idx_base;

  function automatic logic [PFX_CNT_W-1:0] sat_inc(input logic [PFX_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // One-deep skid: a new byte may land while the record is being taken.
  assign bus.byte_ready = !rec_vld_q || bus.instr_ready;
  assign accept         = bus.byte_valid && bus.byte_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    emit    = 1'b0;
    e_grp   = GRP_BASE;
    e_idx   = IDX_HL;
    // IDLE starts a fresh sequence regardless of leftovers in the registers.
    if (state_q == S_IDLE) begin
      cnt_base = '0;
      idx_base = IDX_HL;
    end else begin
      cnt_base = cnt_q;
      idx_base = idx_q;
    end

    if (accept) begin
      case (state_q)
        S_IDLE, S_P_XY: begin
          if (bus.byte_in == PFX_DD) begin
            state_d = S_P_XY;
            idx_d   = IDX_IX;
            cnt_d   = sat_inc(cnt_base);
          end else if (bus.byte_in == PFX_FD) begin
            state_d = S_P_XY;
            idx_d   = IDX_IY;
            cnt_d   = sat_inc(cnt_base);
          end else if (bus.byte_in == PFX_ED) begin
            state_d = S_P_ED;
            idx_d   = IDX_HL;
            cnt_d   = sat_inc(cnt_base);
          end else if (bus.byte_in == PFX_CB) begin
            if (state_q == S_IDLE) begin
              state_d = S_P_CB;
            end else begin
              state_d = S_XYCB_D;
            end
            idx_d = idx_base;
            cnt_d = sat_inc(cnt_base);
          end else begin
            emit  = 1'b1;
            e_grp = GRP_BASE;
            e_idx = idx_base;
          end
        end
        S_P_CB: begin
          emit  = 1'b1;
          e_grp = GRP_CB;
        end
        S_P_ED: begin
          emit  = 1'b1;
          e_grp = GRP_ED;
        end
        S_XYCB_D: begin
          disp_d  = bus.byte_in;
          state_d = S_XYCB_OP;
        end
        S_XYCB_OP: begin
          emit  = 1'b1;
          e_grp = GRP_XYCB;
          e_idx = idx_q;
        end
        default: state_d = S_IDLE;
      endcase

      if (emit) begin
        state_d = S_IDLE;
        idx_d   = IDX_HL;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_HL;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

  // Record register: overwritten with no bubble when a final byte lands
  // in the same cycle the previous record is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_vld_q  <= 1'b0;
      rec_op_q   <= '0;
      rec_grp_q  <= GRP_BASE;
      rec_idx_q  <= IDX_HL;
      rec_disp_q <= '0;
      rec_np_q   <= '0;
    end else if (accept && emit) begin
      rec_vld_q  <= 1'b1;
      rec_op_q   <= bus.byte_in;
      rec_grp_q  <= e_grp;
      rec_idx_q  <= e_idx;
      rec_disp_q <= (e_grp == GRP_XYCB) ? disp_q : '0;
      rec_np_q   <= cnt_base;
    end else if (bus.instr_ready) begin
      rec_vld_q  <= 1'b0;
    end
  end

  assign bus.instr_valid = rec_vld_q;
  assign bus.opcode      = rec_op_q;
  assign bus.grp         = rec_grp_q;
  assign bus.idx         = rec_idx_q;
  assign bus.disp        = rec_disp_q;
  assign bus.nprefix     = rec_np_q;
  assign bus.in_prefix   = (state_q != S_IDLE);
  assign bus.int_ok      = (state_q == S_IDLE) && !rec_vld_q;

endmodule

// File: tb/tb_tv80_prefix_seq.sv
module tb_tv80_prefix_seq;

  typedef struct packed {
    logic [7:0] op;
    logic [1:0] grp;
    logic [1:0] idx;
    logic [7:0] disp;
    logic [3:0] np;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tv80_prefix_seq_if #(.PFX_CNT_W(4)) bus ();
  tv80_prefix_seq #(.PFX_CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   n_chk  = 0;
  int   n_fail = 0;
  rec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic [7:0] op, input logic [1:0] grp, input logic [1:0] idx,
                            input logic [7:0] disp, input logic [3:0] np);
    rec_t r;
    r.op = op; r.grp = grp; r.idx = idx; r.disp = disp; r.np = np;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [7:0] b);
    int cyc;
    cyc = 0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(negedge clk);
    while (!bus.byte_ready && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    if (!bus.byte_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted, byte_ready=%0b required 1", b, bus.byte_ready);
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  // Monitor: every record taken by the executor is popped and compared.
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && bus.instr_ready) begin
      rec_t a, e;
      a.op = bus.opcode; a.grp = bus.grp; a.idx = bus.idx; a.disp = bus.disp; a.np = bus.nprefix;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got op=%0h grp=%0d idx=%0d disp=%0h np=%0d, required none",
                 a.op, a.grp, a.idx, a.disp, a.np);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL record: got op=%0h grp=%0d idx=%0d disp=%0h np=%0d, required op=%0h grp=%0d idx=%0d disp=%0h np=%0d",
                   a.op, a.grp, a.idx, a.disp, a.np, e.op, e.grp, e.idx, e.disp, e.np);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.byte_valid  = 1'b0;
    bus.byte_in     = 8'h00;
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",   {31'd0, bus.instr_valid}, 32'd0);
    check("rst_fields",  {bus.opcode, bus.grp, bus.idx, bus.disp, bus.nprefix}, 32'd0);
    check("rst_inpfx",   {31'd0, bus.in_prefix}, 32'd0);
    check("rst_intok",   {31'd0, bus.int_ok}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // DD 04: INC B with IX selected, one prefix
    send(8'hDD);
    check("dd04_intok_pfx", {31'd0, bus.int_ok}, 32'd0);
    check("dd04_inpfx",     {31'd0, bus.in_prefix}, 32'd1);
    expect_rec(8'h04, 2'b00, 2'b01, 8'h00, 4'd1);
    send(8'h04);
    check("dd04_intok_rec", {31'd0, bus.int_ok}, 32'd0);
    @(posedge clk); #1;
    check("dd04_intok_after", {31'd0, bus.int_ok}, 32'd1);

    // FD CB 05 C6
    send(8'hFD);
    send(8'hCB);
    check("xycb_inpfx_cb", {31'd0, bus.in_prefix}, 32'd1);
    send(8'h05);
    check("xycb_inpfx_d", {31'd0, bus.in_prefix}, 32'd1);
    expect_rec(8'hC6, 2'b11, 2'b10, 8'h05, 4'd2);
    send(8'hC6);

    // DD FD DD 21: last prefix wins
    send(8'hDD); send(8'hFD); send(8'hDD);
    expect_rec(8'h21, 2'b00, 2'b01, 8'h00, 4'd3);
    send(8'h21);

    // DD ED 44: ED cancels DD
    send(8'hDD); send(8'hED);
    expect_rec(8'h44, 2'b10, 2'b00, 8'h00, 4'd2);
    send(8'h44);

    // CB DD: DD is the opcode; then plain 00
    send(8'hCB);
    expect_rec(8'hDD, 2'b01, 2'b00, 8'h00, 4'd1);
    send(8'hDD);
    expect_rec(8'h00, 2'b00, 2'b00, 8'h00, 4'd0);
    send(8'h00);

    // 20 x DD then 00: counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      send(8'hDD);
      check($sformatf("ddrun_intok_%0d", i), {31'd0, bus.int_ok}, 32'd0);
    end
    expect_rec(8'h00, 2'b00, 2'b01, 8'h00, 4'd15);
    send(8'h00);
    @(posedge clk); #1;

    // Stall: record held stable, no byte accepted
    bus.instr_ready = 1'b0;
    expect_rec(8'h3E, 2'b00, 2'b00, 8'h00, 4'd0);
    send(8'h3E);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_bready_%0d", i), {31'd0, bus.byte_ready}, 32'd0);
      check($sformatf("stall_rec_%0d", i), {23'd0, bus.instr_valid, bus.opcode}, {23'd0, 1'b1, 8'h3E});
    end
    @(posedge clk); #1;
    expect_rec(8'h11, 2'b00, 2'b00, 8'h00, 4'd0);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    @(posedge clk); #1;

    // Reset mid-sequence after FD CB
    send(8'hFD);
    send(8'hCB);
    reset = 1'b1;
    #2;
    check("midrst_valid",  {31'd0, bus.instr_valid}, 32'd0);
    check("midrst_fields", {bus.opcode, bus.grp, bus.idx, bus.disp, bus.nprefix}, 32'd0);
    check("midrst_inpfx",  {31'd0, bus.in_prefix}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    expect_rec(8'h04, 2'b00, 2'b00, 8'h00, 4'd0);
    send(8'h04);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tv80_prefix_seq.md
Name: tv80_prefix_seq

Overview:
- Opcode-prefix sequencer for the tv80 decode path.
- Consumes the opcode and displacement bytes fetched in M1/M2, then tracks the DD/FD/CB/ED prefix chains, including DD CB d op, repeated prefixes and prefixes that are ignored (e.g. DD 04 behaves as INC B).
- Emits one decoded-instruction record per instruction to the microcode sequencer.
- Also reports whether an interrupt may be accepted, which is never between a prefix and its opcode.

Parameters:
- PFX_CNT_W, 4, width of the prefix counter; the counter saturates at 2**PFX_CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- byte_valid  in  1  fetched byte available
- byte_ready  out  1  sequencer accepts the byte this cycle
- byte_in  in  8  fetched opcode or displacement byte
- instr_valid  out  1  decoded record valid
- instr_ready  in  1  executor takes the record
- opcode  out  8  final opcode byte
- grp  out  2  00 base, 01 CB, 10 ED, 11 XYCB (DD/FD CB)
- idx  out  2  00 HL, 01 IX, 10 IY
- disp  out  8  displacement; valid only when grp=11
- nprefix  out  PFX_CNT_W  number of prefix bytes consumed, saturating
- in_prefix  out  1  high while a sequence is partially consumed
- int_ok  out  1  interrupt acceptance allowed

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted: state=IDLE, instr_valid=0, opcode=0, grp=0, idx=0, disp=0, nprefix=0, in_prefix=0. A reset in the middle of a sequence discards it; the next byte is decoded from IDLE.
- A byte is accepted when byte_valid && byte_ready. byte_ready = !instr_valid || instr_ready, which gives a one-deep skid.
- The output record is registered. instr_valid rises the cycle after the final byte is accepted and stays high with stable fields until instr_ready. A new final byte accepted in the same cycle as instr_ready overwrites the record with no bubble.
- States: IDLE, P_XY, P_CB, P_ED, XYCB_D, XYCB_OP. An internal idx_r holds the current index selection.
- IDLE or P_XY:
  - DD → P_XY, idx_r=IX.
  - FD → P_XY, idx_r=IY. The last prefix wins, so DD FD gives IY.
  - ED → P_ED, idx_r=HL. ED cancels any DD/FD.
  - CB: from IDLE → P_CB; from P_XY → XYCB_D.
  - Any other byte: emit grp=00, idx=idx_r, then → IDLE.
- P_CB: any byte, including DD/FD/ED/CB, is the opcode. Emit grp=01, idx=00, then → IDLE.
- P_ED: any byte is the opcode. Emit grp=10, idx=00, then → IDLE.
- XYCB_D: the byte is latched as disp, then → XYCB_OP.
- XYCB_OP: the byte is the opcode. Emit grp=11, idx=idx_r, disp, then → IDLE.
- nprefix: incremented on each DD/FD/ED/CB prefix byte, saturating. It counts the CB after DD/FD but not the displacement. It is copied into the record on emit and cleared in IDLE. The executor uses it for extra M1 T-states: DD 04 gives nprefix=1, total 8 T-states.
- The block does not decide whether the index register is actually used. idx passes through; the executor substitutes only for H/L/(HL) references. DD 04 therefore yields idx=IX, opcode=04, and the executor performs INC B.
- in_prefix = (state != IDLE).
- int_ok = (state == IDLE) && !instr_valid. It is 0 throughout any prefix chain, including an unbounded run of DD DD DD….
- An unbroken prefix run never emits a record; only the terminating opcode does.

Decomposition:
- Package tv80_pkg holds:
  - grp_t enum (GRP_BASE, GRP_CB, GRP_ED, GRP_XYCB);
  - idx_t enum (IDX_HL, IDX_IX, IDX_IY);
  - prefix constants PFX_DD=8'hDD, PFX_FD=8'hFD, PFX_ED=8'hED, PFX_CB=8'hCB;
  - pfx_state_t enum.
- No sub-module: the FSM and the output register fit in one module of about 200 lines.

Test Plan:
- DD 04, instr_ready=1 → one record: opcode=04, grp=00, idx=01, nprefix=1; int_ok low for exactly one cycle between the bytes.
- FD CB 05 C6 → record: opcode=C6, grp=11, idx=10, disp=05, nprefix=2; no record after FD or CB.
- DD FD DD 21 → opcode=21, idx=01, nprefix=3. DD ED 44 → grp=10, idx=00, opcode=44.
- CB DD → grp=01, opcode=DD (DD is treated as the opcode); the next 00 gives grp=00, idx=00, nprefix=0.
- 20 consecutive DD, then 00 → nprefix=15 (saturated), idx=01; int_ok low throughout.
- Hold instr_ready=0 after emitting 3E: byte_ready=0 and fields stable for 5 cycles. Assert reset after FD CB: all outputs 0, then 04 → grp=00, idx=00.
